addsubcmp_seq: RTL and testbench

- Word-serial sequencer for one shared AddSubCmp datapath instance. Performs multi-word (Len_i+1 words, least significant word first) add, subtract or compare by chaining carry/borrow between words.
- Accepts operand word pairs over a valid/ready handshake, streams result words out and reports whole-operand flags at completion.
- Sits between a requester (CPU/reconfigurable FSM) and the ALU cell, whose ports it drives directly.

---
 rtl/addsubcmp_seq.sv | 141 ++++++++++++++
 tb/tb_addsubcmp_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsubcmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsubcmp_seq
// Purpose  : Word-serial add/sub/compare sequencer that drives one shared
//            AddSubCmp ALU cell, chaining carry/borrow between words.
// Revision : 1.0 - initial release
// ============================================================================
module addsubcmp_seq #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic                 Start_i,
    input  logic                 Abort_i,
    input  logic [1:0]           Op_i,
    input  logic [CNT_WIDTH-1:0] Len_i,
    output logic                 Busy_o,
    output logic                 Done_o,
    input  logic [WIDTH-1:0]     OpA_i,
    input  logic [WIDTH-1:0]     OpB_i,
    input  logic                 OpValid_i,
    output logic                 OpReady_o,
    output logic [WIDTH-1:0]     Res_o,
    output logic                 ResValid_o,
    output logic                 Carry_o,
    output logic                 Zero_o,
    output logic                 Sign_o,
    output logic                 Overflow_o,
    output logic                 AluAddOrSub_o,
    output logic [WIDTH-1:0]     AluA_o,
    output logic [WIDTH-1:0]     AluB_o,
    output logic                 AluCarry_o,
    input  logic [WIDTH-1:0]     AluD_i,
    input  logic                 AluCarry_i,
    input  logic                 AluZero_i,
    input  logic                 AluSign_i,
    input  logic                 AluOverflow_i
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_CMP = 2'b10;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_carry;
    logic                 r_zero_acc;
    logic [WIDTH-1:0]     r_res;
    logic                 r_res_valid;
    logic                 r_done;
    logic                 r_carry_flag;
    logic                 r_zero_flag;
    logic                 r_sign_flag;
    logic                 r_ovf_flag;

    logic                 w_is_add;
    logic                 w_is_cmp;

    assign w_is_add = (r_op == c_OP_ADD);
    assign w_is_cmp = (r_op == c_OP_CMP);

    assign Busy_o     = (r_state == S_RUN);
    assign OpReady_o  = (r_state == S_RUN);
    assign Done_o     = r_done;
    assign Res_o      = r_res;
    assign ResValid_o = r_res_valid;
    assign Carry_o    = r_carry_flag;
    assign Zero_o     = r_zero_flag;
    assign Sign_o     = r_sign_flag;
    assign Overflow_o = r_ovf_flag;

    // The ALU inverts its carry input when subtracting, so pre-invert here to
    // make the effective carry-in equal r_carry in every mode.
    assign AluAddOrSub_o = ~w_is_add;
    assign AluA_o        = OpA_i;
    assign AluB_o        = OpB_i;
    assign AluCarry_o    = w_is_add ? r_carry : ~r_carry;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            r_state      <= S_IDLE;
            r_op         <= c_OP_ADD;
            r_len        <= '0;
            r_cnt        <= '0;
            r_carry      <= 1'b0;
            r_zero_acc   <= 1'b1;
            r_res        <= '0;
            r_res_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_carry_flag <= 1'b0;
            r_zero_flag  <= 1'b1;
            r_sign_flag  <= 1'b0;
            r_ovf_flag   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start_i) begin
                        r_op       <= Op_i;
                        r_len      <= Len_i;
                        r_cnt      <= '0;
                        r_zero_acc <= 1'b1;
                        r_carry    <= (Op_i != c_OP_ADD);
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort wins over a word offered in the same cycle.
                    if (Abort_i) begin
                        r_state <= S_IDLE;
                    end else if (OpValid_i) begin
                        r_carry     <= AluCarry_i;
                        r_zero_acc  <= r_zero_acc & AluZero_i;
                        r_res       <= AluD_i;
                        r_res_valid <= ~w_is_cmp;
                        r_cnt       <= r_cnt + 1'b1;
                        if (r_cnt == r_len) begin
                            r_carry_flag <= AluCarry_i;
                            r_sign_flag  <= AluSign_i;
                            r_ovf_flag   <= AluOverflow_i;
                            r_zero_flag  <= r_zero_acc & AluZero_i;
                            r_done       <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsubcmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsubcmp_seq
// Purpose  : Scoreboard bench for addsubcmp_seq with an AddSubCmp ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsubcmp_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [1:0]       len = 2'b00;
    logic             busy, done;
    logic [WIDTH-1:0] opa = '0, opb = '0;
    logic             opvalid = 1'b0;
    logic             opready;
    logic [WIDTH-1:0] res;
    logic             resvalid;
    logic             carry_f, zero_f, sign_f, ovf_f;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_a, alu_b, alu_d;
    logic             alu_cin, alu_cout, alu_zero, alu_sign, alu_ovf;

    always #5 clk = ~clk;

    addsubcmp_seq dut (
        .Clk_i(clk), .Reset_i(rst), .Start_i(start), .Abort_i(abort),
        .Op_i(op), .Len_i(len), .Busy_o(busy), .Done_o(done),
        .OpA_i(opa), .OpB_i(opb), .OpValid_i(opvalid), .OpReady_o(opready),
        .Res_o(res), .ResValid_o(resvalid),
        .Carry_o(carry_f), .Zero_o(zero_f), .Sign_o(sign_f), .Overflow_o(ovf_f),
        .AluAddOrSub_o(alu_sub), .AluA_o(alu_a), .AluB_o(alu_b),
        .AluCarry_o(alu_cin), .AluD_i(alu_d), .AluCarry_i(alu_cout),
        .AluZero_i(alu_zero), .AluSign_i(alu_sign), .AluOverflow_i(alu_ovf)
    );

    // ALU cell model: subtract inverts B and the carry input.
    logic [WIDTH-1:0] w_beff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    always_comb begin
        w_beff   = alu_sub ? ~alu_b : alu_b;
        w_cin    = alu_sub ? ~alu_cin : alu_cin;
        w_sum    = {1'b0, alu_a} + {1'b0, w_beff} + {{WIDTH{1'b0}}, w_cin};
        alu_d    = w_sum[WIDTH-1:0];
        alu_cout = w_sum[WIDTH];
        alu_zero = (w_sum[WIDTH-1:0] == '0);
        alu_sign = w_sum[WIDTH-1];
        alu_ovf  = (alu_a[WIDTH-1] == w_beff[WIDTH-1]) && (w_sum[WIDTH-1] != alu_a[WIDTH-1]);
    end

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] res_q[$];
    logic [3:0]       flag_q[$];   // {carry, zero, sign, overflow}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result or completion.
    always @(negedge clk) begin
        if (!rst && resvalid) begin
            if (res_q.size() == 0) chk("unexpected_resvalid", 1, 0);
            else chk("res_word", {16'h0, res}, {16'h0, res_q.pop_front()});
        end
        if (!rst && done) begin
            if (flag_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("final_flags", {28'h0, carry_f, zero_f, sign_f, ovf_f},
                     {28'h0, flag_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [1:0] l, input logic [3:0] exp_flags);
        flag_q.push_back(exp_flags);
        start = 1'b1; op = o; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] exp_res, input bit expect_res);
        bit ok = 0;
        opa = a; opb = b; opvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (opready) begin ok = 1; break; end
        end
        if (!ok) chk("opready_timeout", 0, 1);
        if (expect_res) res_q.push_back(exp_res);
        tick();
        opvalid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("done_timeout", 0, 1);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     {31'h0, busy},     0);
        chk({tag, "_done"},     {31'h0, done},     0);
        chk({tag, "_opready"},  {31'h0, opready},  0);
        chk({tag, "_resvalid"}, {31'h0, resvalid}, 0);
        chk({tag, "_res"},      {16'h0, res},      0);
        chk({tag, "_flags"},    {28'h0, carry_f, zero_f, sign_f, ovf_f}, 32'h4);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // Add Len=1: 0x0001FFFF + 0x00000001 = 0x00020000
        start_op(2'b00, 2'd1, 4'b0000);
        chk("busy_after_start", {31'h0, busy}, 1);
        send_word(16'hFFFF, 16'h0001, 16'h0000, 1);
        send_word(16'h0001, 16'h0000, 16'h0002, 1);
        wait_idle();

        // Sub Len=1: 0x00010000 - 1 = 0x0000FFFF, no final borrow
        start_op(2'b01, 2'd1, 4'b1000);
        send_word(16'h0000, 16'h0001, 16'hFFFF, 1);
        send_word(16'h0001, 16'h0000, 16'h0000, 1);
        wait_idle();

        // Cmp equal 0x12345678: no result words
        start_op(2'b10, 2'd1, 4'b1100);
        send_word(16'h5678, 16'h5678, 16'h0, 0);
        send_word(16'h1234, 16'h1234, 16'h0, 0);
        wait_idle();

        // Cmp 0 vs 1: borrow out, negative
        start_op(2'b10, 2'd1, 4'b0010);
        send_word(16'h0000, 16'h0001, 16'h0, 0);
        send_word(16'h0000, 16'h0000, 16'h0, 0);
        wait_idle();

        // Op 11 behaves as sub, Len=0: 5 - 3 = 2
        start_op(2'b11, 2'd0, 4'b1000);
        send_word(16'h0005, 16'h0003, 16'h0002, 1);
        wait_idle();

        // 4-word add with gaps and a Start pulse while busy:
        // 0x0123456789ABCDEF + 0xFEDCBA9876543211 = 0x1_0000000000000000
        start_op(2'b00, 2'd3, 4'b1100);
        send_word(16'hCDEF, 16'h3211, 16'h0000, 1);
        send_word(16'h89AB, 16'h7654, 16'h0000, 1);
        start = 1'b1; op = 2'b01; len = 2'd0; opa = 16'hDEAD;
        tick();
        start = 1'b0;
        tick();
        send_word(16'h4567, 16'hBA98, 16'h0000, 1);
        repeat (3) tick();
        send_word(16'h0123, 16'hFEDC, 16'h0000, 1);
        wait_idle();

        // Signed overflow, Len=0: 0x7FFF + 1
        start_op(2'b00, 2'd0, 4'b0011);
        send_word(16'h7FFF, 16'h0001, 16'h8000, 1);
        wait_idle();

        // Abort alongside the second word of a 4-word op
        flag_q.push_back(4'b0000);
        void'(flag_q.pop_back());
        start = 1'b1; op = 2'b00; len = 2'd3;
        tick();
        start = 1'b0;
        send_word(16'h1111, 16'h2222, 16'h3333, 1);
        opa = 16'h0001; opb = 16'h0001; opvalid = 1'b1; abort = 1'b1;
        tick();
        opvalid = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_flags_held", {28'h0, carry_f, zero_f, sign_f, ovf_f}, 32'h3);
        repeat (3) tick();

        // Asynchronous reset in the middle of an operation
        start = 1'b1; op = 2'b01; len = 2'd3;
        tick();
        start = 1'b0;
        send_word(16'h0005, 16'h0001, 16'h0004, 1);
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset_outputs("async_reset");
        tick();
        rst = 1'b0;
        tick();

        chk("res_queue_drained",  res_q.size(), 0);
        chk("flag_queue_drained", flag_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
